// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter
package dmem_arb_pkg;
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;
    localparam int WORD_IDX_HI   = 9;
    localparam int WORD_IDX_LO   = 2;
    localparam int DEF_MAX_WAIT  = 4;
    localparam int DEF_MAX_BURST = 8;
endpackage

// File: rtl/arb_sat_counter.sv
// arb_sat_counter: clearable up-counter that saturates at LIMIT
module arb_sat_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or posedge reset)
        if (reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && r_cnt != W'(LIMIT))
            r_cnt <= r_cnt + 1'b1;
    assign o_cnt = r_cnt;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the CPU MEM stage and a DMA engine
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_cpu_rd,
    input  logic        i_cpu_wr,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_stall,
    input  logic        i_dma_req,
    input  logic        i_dma_we,
    input  logic        i_dma_lock,
    input  logic [31:0] i_dma_addr,
    input  logic [31:0] i_dma_wdata,
    output logic        o_dma_gnt,
    output logic        o_dma_ack,
    output logic [31:0] o_dma_rdata,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);
    state_t             r_state;
    logic [CNT_W-1:0]   w_wait_cnt, w_burst_cnt;
    logic               w_cpu_act, w_starve, w_gnt, w_cpu_own, w_lock_next;

    assign w_cpu_act   = i_cpu_rd | i_cpu_wr;
    assign w_starve    = w_wait_cnt == CNT_W'(MAX_WAIT);
    assign w_gnt       = ~reset & i_dma_req & ((r_state == LOCKED) | ~w_cpu_act | w_starve);
    assign w_cpu_own   = ~reset & w_cpu_act & ~w_gnt;
    // burst_cnt is 0 in IDLE, so one compare covers both entry and continuation
    assign w_lock_next = w_gnt & i_dma_lock & (w_burst_cnt < CNT_W'(MAX_BURST - 1));

    arb_sat_counter #(.W(CNT_W), .LIMIT(MAX_WAIT)) u_wait (
        .clk(clk), .reset(reset),
        .i_clr(w_gnt | ~i_dma_req), .i_inc(i_dma_req & ~w_gnt),
        .o_cnt(w_wait_cnt)
    );

    arb_sat_counter #(.W(CNT_W), .LIMIT(MAX_BURST)) u_burst (
        .clk(clk), .reset(reset),
        .i_clr(~w_lock_next), .i_inc(w_lock_next),
        .o_cnt(w_burst_cnt)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state     <= IDLE;
            o_dma_ack   <= 1'b0;
            o_dma_rdata <= '0;
        end else begin
            r_state     <= w_lock_next ? LOCKED : IDLE;
            o_dma_ack   <= w_gnt;
            o_dma_rdata <= (w_gnt & ~i_dma_we) ? i_mem_rdata : o_dma_rdata;
        end

    assign o_dma_gnt   = w_gnt;
    assign o_cpu_stall = ~reset & w_cpu_act & w_gnt;
    assign o_cpu_rdata = w_cpu_own ? i_mem_rdata : '0;
    assign o_mem_read  = w_gnt ? ~i_dma_we : w_cpu_own & i_cpu_rd;
    assign o_mem_write = w_gnt ? i_dma_we : w_cpu_own & i_cpu_wr;
    assign o_mem_addr  = w_gnt ? i_dma_addr : w_cpu_own ? i_cpu_addr : '0;
    assign o_mem_wdata = w_gnt ? i_dma_wdata : w_cpu_own ? i_cpu_wdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors with a queued scoreboard checked on the falling edge
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0, reset = 1'b1;
    logic        cpu_rd = 0, cpu_wr = 0, dma_req = 0, dma_we = 0, dma_lock = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_stall, dma_gnt, dma_ack, mem_read, mem_write;
    logic [31:0] mem [256];

    typedef struct {
        string       nm;
        logic        g, s, mr, mw;
        logic [31:0] ma, cr;
        logic        ack;
        logic [31:0] dr;
    } exp_t;
    exp_t q[$];
    int   n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
        .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_lock(dma_lock),
        .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
        .o_dma_gnt(dma_gnt), .o_dma_ack(dma_ack), .o_dma_rdata(dma_rdata),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem_read ? mem[mem_addr[WORD_IDX_HI:WORD_IDX_LO]] : 32'h0;
    always @(posedge clk) if (mem_write) mem[mem_addr[WORD_IDX_HI:WORD_IDX_LO]] <= mem_wdata;

    task automatic chk(input string nm, input string f, input logic [31:0] a, input logic [31:0] e);
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s.%s got %h expected %h", nm, f, a, e);
        end
    endtask

    always @(negedge clk)
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            chk(e.nm, "dma_gnt", {31'b0, dma_gnt}, {31'b0, e.g});
            chk(e.nm, "cpu_stall", {31'b0, cpu_stall}, {31'b0, e.s});
            chk(e.nm, "mem_read", {31'b0, mem_read}, {31'b0, e.mr});
            chk(e.nm, "mem_write", {31'b0, mem_write}, {31'b0, e.mw});
            chk(e.nm, "mem_addr", mem_addr, e.ma);
            chk(e.nm, "cpu_rdata", cpu_rdata, e.cr);
            chk(e.nm, "dma_ack", {31'b0, dma_ack}, {31'b0, e.ack});
            chk(e.nm, "dma_rdata", dma_rdata, e.dr);
        end

    task automatic v(input string nm, input logic rst, input logic crd, input logic cwr,
                     input logic [31:0] ca, input logic [31:0] cw,
                     input logic dreq, input logic dwe, input logic dlk,
                     input logic [31:0] da, input logic [31:0] dw,
                     input logic g, input logic s, input logic mr, input logic mw,
                     input logic [31:0] ma, input logic [31:0] cr,
                     input logic ack, input logic [31:0] dr);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; cpu_rd = crd; cpu_wr = cwr; cpu_addr = ca; cpu_wdata = cw;
        dma_req = dreq; dma_we = dwe; dma_lock = dlk; dma_addr = da; dma_wdata = dw;
        e.nm = nm; e.g = g; e.s = s; e.mr = mr; e.mw = mw; e.ma = ma; e.cr = cr; e.ack = ack; e.dr = dr;
        q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic ack, input logic [31:0] dr);
        v(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ack, dr);
    endtask

    localparam logic [31:0] D0 = 32'h1234_5678;
    localparam logic [31:0] A0 = 32'hA000_0000;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        v("rst0", 1, 0, 1, 32'h10, D0, 1, 0, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v("rst1", 1, 0, 1, 32'h10, D0, 1, 0, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v("post_rst_cpu", 0, 0, 1, 32'h10, D0, 1, 0, 0, 32'h40, 0, 0, 0, 0, 1, 32'h10, 0, 0, 0);
        v("dma_rd", 0, 0, 0, 0, 0, 1, 0, 0, 32'h10, 0, 1, 0, 1, 0, 32'h10, 0, 0, 0);
        idle("dma_ack", 1, D0);
        for (int i = 0; i < 10; i++) begin
            logic g;
            g = (i % 5 == 4);
            v("contend", 0, 1, 0, 32'h10, 0, 1, 1, 0, 32'h20, 32'hCAFE_0001,
              g, g, !g, g, g ? 32'h20 : 32'h10, g ? 32'h0 : D0, i == 5, D0);
        end
        idle("contend_end", 1, D0);
        for (int k = 0; k < 8; k++)
            v("burst", 0, 0, 0, 0, 0, 1, 1, 1, 32'h100 + 4 * k, A0 + k,
              1, 0, 0, 1, 32'h100 + 4 * k, 0, k != 0, D0);
        v("burst_release", 0, 1, 0, 32'h100, 0, 1, 1, 1, 32'h120, A0 + 8,
          0, 0, 1, 0, 32'h100, A0, 1, D0);
        for (int k = 9; k < 12; k++)
            v("burst2", 0, 0, 0, 0, 0, 1, 1, 1, 32'h100 + 4 * k, A0 + k,
              1, 0, 0, 1, 32'h100 + 4 * k, 0, k != 9, D0);
        idle("burst_end", 1, D0);
        for (int c = 0; c < 13; c++) begin
            logic g;
            g = (c >= 4) && (c <= 11);
            v("stall", 0, 1, 0, 32'h11C, 0, 1, 0, 1, 32'h104, 0,
              g, g, 1, 0, g ? 32'h104 : 32'h11C, g ? 32'h0 : A0 + 7, c >= 5, c >= 5 ? A0 + 1 : D0);
        end
        idle("stall_end", 0, A0 + 1);
        for (int c = 0; c < 3; c++)
            v("pre_rst_burst", 0, 0, 0, 0, 0, 1, 0, 1, 32'h108, 0,
              1, 0, 1, 0, 32'h108, 0, c != 0, c == 0 ? A0 + 1 : A0 + 2);
        v("mid_burst_rst", 1, 0, 0, 0, 0, 1, 0, 1, 32'h108, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 8; r++)
            v("restart", 0, 0, 0, 0, 0, 1, 0, 1, 32'h108, 0,
              1, 0, 1, 0, 32'h108, 0, r != 0, r != 0 ? A0 + 2 : 32'h0);
        v("restart_release", 0, 1, 0, 32'h10, 0, 1, 0, 1, 32'h108, 0,
          0, 0, 1, 0, 32'h10, D0, 1, A0 + 2);
        idle("final", 0, A0 + 2);
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending %0d required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipelined CPU MEM stage (port C) and a DMA/loader engine (port D).
- Sits between both masters and the data memory.
- Memory timing: combinational read when mem_read=1; write on the clk edge when mem_write=1; word index is address bits [9:2].
- CPU has default priority. DMA gets anti-starvation promotion and an optional bounded locked burst. CPU is held off through cpu_stall.

Parameters:
- MAX_WAIT, 4: consecutive denied DMA cycles after which DMA wins over CPU.
- MAX_BURST, 8: maximum consecutive locked DMA grants before a forced release.
- CNT_W, 4: width of the wait and burst counters; must hold max(MAX_WAIT, MAX_BURST).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cpu_rd  in  1  CPU MEM-stage load
- cpu_wr  in  1  CPU MEM-stage store
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU store data
- cpu_rdata  out  32  load data; mem_rdata when CPU owns the cycle, else 0
- cpu_stall  out  1  CPU request not served this cycle; pipeline must freeze
- dma_req  in  1  DMA access request, one access per granted cycle
- dma_we  in  1  1 = write, 0 = read
- dma_lock  in  1  request locked burst
- dma_addr  in  32  DMA byte address
- dma_wdata  in  32  DMA write data
- dma_gnt  out  1  combinational; the access is performed this cycle
- dma_ack  out  1  registered; dma_gnt delayed one cycle
- dma_rdata  out  32  registered read data, valid with dma_ack
- mem_read  out  1  to memory
- mem_write  out  1  to memory
- mem_addr  out  32  to memory
- mem_wdata  out  32  to memory
- mem_rdata  in  32  from memory

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - Forces state=IDLE, wait_cnt=0, burst_cnt=0, dma_ack=0, dma_rdata=0.
  - While reset is high: dma_gnt=0, cpu_stall=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, cpu_rdata=0.
  - Reset mid-burst abandons the burst; no partial state survives.
- Definitions: cpu_act = cpu_rd|cpu_wr; starve = (wait_cnt == MAX_WAIT).
- States:
  - IDLE: dma_gnt = dma_req & (~cpu_act | starve).
  - LOCKED: dma_gnt = dma_req.
- Ownership:
  - CPU owns the cycle iff cpu_act & ~dma_gnt.
  - cpu_stall = cpu_act & dma_gnt.
  - No owner means mem_read=mem_write=0 and mem_addr/mem_wdata=0.
- Memory mux:
  - DMA owner: mem_read=~dma_we, mem_write=dma_we, DMA address/data.
  - CPU owner: mem_read=cpu_rd, mem_write=cpu_wr, CPU address/data.
  - cpu_rd and cpu_wr both high is passed through unchanged; the memory performs both.
- Transitions:
  - IDLE→LOCKED when dma_gnt & dma_lock & (MAX_BURST > 1); burst_cnt ← 1.
  - LOCKED→LOCKED when dma_gnt & dma_lock & (burst_cnt < MAX_BURST-1); burst_cnt+1.
  - LOCKED→IDLE when ~dma_req, ~dma_lock, or a grant reaches burst_cnt = MAX_BURST-1. The burst therefore totals exactly MAX_BURST grants; burst_cnt ← 0.
  - A forced release always returns to IDLE, so a requesting CPU wins the next cycle unless starve is set. wait_cnt is 0 at that point, so the CPU is guaranteed that cycle.
- wait_cnt:
  - Clears on every dma_gnt or ~dma_req.
  - Increments when dma_req & ~dma_gnt; saturates at MAX_WAIT.
- dma_ack ← dma_gnt.
- dma_rdata ← mem_rdata when dma_gnt & ~dma_we; otherwise holds.
- Latency:
  - CPU access has zero added latency when not stalled.
  - DMA access occurs in the dma_gnt cycle; dma_ack follows one cycle later.
- Boundaries:
  - Simultaneous requests resolve to CPU unless starve or LOCKED.
  - dma_lock without dma_req has no effect.
  - The bus is idle when nobody requests.
  - Worst-case DMA wait is MAX_WAIT cycles.
  - Worst-case CPU stall is MAX_BURST cycles.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state enumeration: IDLE=1'b0, LOCKED=1'b1;
  - localparam WORD_IDX_HI=9, WORD_IDX_LO=2;
  - default MAX_WAIT and MAX_BURST.
- One sub-module, arb_sat_counter (clear, inc, saturate at a limit, async reset), instantiated twice: once for wait_cnt, once for burst_cnt.

Test Plan:
- Reset with both requesting → dma_gnt=0, cpu_stall=0, mem_write=0, dma_ack=0. First clk after release: CPU owns the cycle, mem_addr=cpu_addr.
- CPU store 0x1234_5678 @0x10 alone → mem_write=1 that cycle. Then DMA read @0x10 alone → dma_gnt=1; next cycle dma_ack=1, dma_rdata=0x1234_5678.
- CPU and DMA requesting continuously, MAX_WAIT=4 → CPU owns 4 cycles; cycle 5 dma_gnt=1, cpu_stall=1; wait_cnt returns to 0 and the pattern repeats with period 5.
- DMA locked write burst, 12 words, CPU idle, MAX_BURST=8 → 8 consecutive grants, then one IDLE re-entry; with CPU now requesting, the CPU owns that cycle.
- Locked burst with CPU load pending → cpu_stall=1 for exactly 8 cycles. cpu_rdata=0 while stalled; CPU served on cycle 9.
- Reset asserted mid-burst (burst_cnt=3) → immediate IDLE, dma_ack=0, dma_rdata=0. After release with CPU idle and dma_req high, burst restarts at count 1.
